// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared state encoding, NOP constant and address helpers for imem_loadable.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  localparam logic [63:0] NOP_WORD = 64'h0;

  function automatic logic [61:0] word_idx(input logic [63:0] addr);
    return 62'(addr >> 2);
  endfunction

  function automatic logic in_range(input logic [61:0] idx, input int unsigned depth);
    return idx < 62'(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_ram
// Purpose  : Single write port / single registered read port word memory;
//            the read register holds while i_re is low.
// Revision : 1.0 - initial release
// ============================================================================
module imem_ram #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_loadable
// Purpose  : IF-stage instruction memory with clear engine, streaming loader
//            and 1-cycle registered fetch. Optional macro: IMEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic [ADDR_W-1:0]            load_base,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         load_done,
  output logic [$clog2(DEPTH_WORDS):0] load_count,
  output logic                         load_overflow,
  input  logic                         fetch_en,
  input  logic [ADDR_W-1:0]            fetch_addr,
  input  logic                         fetch_stall,
  output logic [DATA_W-1:0]            instruction,
  output logic                         instr_valid,
  output logic                         addr_error,
`ifdef IMEM_PARITY_EN
  output logic                         parity_error,
`endif
  output logic                         busy
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);
  localparam int c_CNT_W = c_IDX_W + 1;
`ifdef IMEM_PARITY_EN
  localparam int c_RAM_W = DATA_W + 1;
`else
  localparam int c_RAM_W = DATA_W;
`endif

  imem_state_t          r_state, w_next_state;
  logic [c_IDX_W-1:0]   r_clr_ptr, r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow, r_done;
  logic                 r_valid, r_err, r_rd_ok;

  logic                 w_we;
  logic [c_IDX_W-1:0]   w_waddr;
  logic [c_RAM_W-1:0]   w_wdata, w_wr_word, w_rdata;
  logic [61:0]          w_base_full, w_fetch_full;
  logic [c_IDX_W-1:0]   w_base_idx;
  logic                 w_fetch_bad, w_serve, w_re;
  logic                 w_unused;

  assign w_base_full  = word_idx(64'(load_base));
  assign w_base_idx   = w_base_full[c_IDX_W-1:0];
  assign w_fetch_full = word_idx(64'(fetch_addr));
  assign w_unused     = ^w_base_full[61:c_IDX_W];

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {^load_data, load_data};
`else
  assign w_wr_word = load_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A load_start in LOAD wins over a same-cycle handshake, so that word is never written.
  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_waddr      = r_wr_ptr;
    w_wdata      = '0;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_ptr;
        if (r_clr_ptr == c_IDX_W'(DEPTH_WORDS - 1)) begin
          w_next_state = IDLE;
        end
      end
      IDLE: begin
        if (load_start) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        if (!load_start && load_valid) begin
          w_we    = 1'b1;
          w_wdata = w_wr_word;
          if (load_last) begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (reset) begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr  <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CLEAR: r_clr_ptr <= r_clr_ptr + 1'b1;
        IDLE, LOAD: begin
          if (load_start) begin
            r_wr_ptr   <= w_base_idx;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end else if (r_state == LOAD && load_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == c_IDX_W'(DEPTH_WORDS - 1)) begin
              r_overflow <= 1'b1;
            end
            if (r_count != c_CNT_W'(DEPTH_WORDS)) begin
              r_count <= r_count + 1'b1;
            end
            r_done <= load_last;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) ||
                       !in_range(w_fetch_full, int'(unsigned'(DEPTH_WORDS)));
  assign w_serve     = !fetch_stall && fetch_en && (r_state == IDLE);
  assign w_re        = w_serve && !w_fetch_bad;

  imem_ram #(
    .WIDTH     (c_RAM_W),
    .DEPTH     (DEPTH_WORDS),
    .ADDR_BITS (c_IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_fetch_full[c_IDX_W-1:0]),
    .o_rdata (w_rdata)
  );

  // The RAM holds its read register when not re-read, so stalls need only these flags to hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else if (!fetch_stall) begin
      r_valid <= w_serve;
      r_err   <= w_serve && w_fetch_bad;
      r_rd_ok <= w_re;
    end
  end

  assign instruction   = r_rd_ok ? w_rdata[DATA_W-1:0] : DATA_W'(NOP_WORD);
  assign instr_valid   = r_valid;
  assign addr_error    = r_err;
`ifdef IMEM_PARITY_EN
  assign parity_error  = r_rd_ok && (^w_rdata);
`endif
  assign load_ready    = (r_state == LOAD);
  assign load_done     = r_done;
  assign load_count    = r_count;
  assign load_overflow = r_overflow;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loadable
// Purpose  : Self-checking bench for imem_loadable (table vectors, directed
//            sequences, randomized loads/fetches against an array model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loadable;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset, load_start, load_valid, load_last;
  logic [AW-1:0] load_base, fetch_addr;
  logic [DW-1:0] load_data, instruction;
  logic          load_ready, load_done, load_overflow;
  logic [8:0]    load_count;
  logic          fetch_en, fetch_stall, instr_valid, addr_error, busy;
`ifdef IMEM_PARITY_EN
  logic          parity_error;
`endif

  always #5 clk = ~clk;

  imem_loadable #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .load_count(load_count), .load_overflow(load_overflow),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .instruction(instruction), .instr_valid(instr_valid), .addr_error(addr_error),
`ifdef IMEM_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy(busy)
  );

  // Reference model: plain word array plus load bookkeeping.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } fvec_t;
  fvec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
  endtask

  task automatic fetch_chk(input logic [31:0] a, input string tag);
    logic        bad;
    logic [31:0] e;
    bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    e   = bad ? 32'h0 : m_mem[a[9:2]];
    fetch_en = 1'b1; fetch_addr = a;
    tick();
    fetch_en = 1'b0;
    chk({tag, " valid"}, 64'(instr_valid), 64'(1));
    chk({tag, " instr"}, 64'(instruction), 64'(e));
    chk({tag, " err"},   64'(addr_error),  64'(bad));
`ifdef IMEM_PARITY_EN
    chk({tag, " parity"}, 64'(parity_error), 64'(0));
`endif
  endtask

  task automatic do_load(input logic [31:0] base, input logic [31:0] d[$], input bit gaps);
    int p;
    load_start = 1'b1; load_base = base;
    tick();
    load_start = 1'b0;
    p = int'((base >> 2) % DEPTH); m_count = 0; m_ovf = 1'b0;
    for (int i = 0; i < d.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin load_valid = 1'b0; tick(); end
      end
      load_valid = 1'b1; load_data = d[i]; load_last = (i == d.size() - 1);
      tick();
      m_mem[p] = d[i];
      if (p == DEPTH - 1) m_ovf = 1'b1;
      p = (p + 1) % DEPTH;
      if (m_count < DEPTH) m_count++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("load_done pulse", 64'(load_done), 64'(1));
    chk("load_count", 64'(load_count), 64'(m_count));
    chk("load_overflow", 64'(load_overflow), 64'(m_ovf));
    chk("busy after load", 64'(busy), 64'(0));
    tick();
    chk("load_done single", 64'(load_done), 64'(0));
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    bit seen;
    cnt = 0; seen = 1'b0;
    while (busy && cnt < 1000) begin
      tick();
      cnt++;
      if (load_done) seen = 1'b1;
    end
    chk({tag, " busy cycles"}, 64'(cnt), 64'(DEPTH));
    chk({tag, " no load_done"}, 64'(seen), 64'(0));
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] a;
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_valid = 1'b0;
    load_data = '0; load_last = 1'b0; fetch_en = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    repeat (3) tick();
    chk("rst instr_valid", 64'(instr_valid), 64'(0));
    chk("rst instruction", 64'(instruction), 64'(0));
    chk("rst addr_error", 64'(addr_error), 64'(0));
    chk("rst load_done", 64'(load_done), 64'(0));
    chk("rst load_count", 64'(load_count), 64'(0));
    chk("rst load_overflow", 64'(load_overflow), 64'(0));
    chk("rst load_ready", 64'(load_ready), 64'(0));
    reset = 1'b0;
    count_clear("power-up clear");
    fetch_chk(32'h3FC, "fetch 0x3FC after clear");

    q = '{32'h2008_0005, 32'h2009_0007};
    do_load(32'h10, q, 1'b0);
    q = '{32'hA5A5_0001, 32'h5A5A_0002};
    do_load(32'h3FC, q, 1'b0);

    tbl[0] = '{32'h10,  32'h2008_0005, 1'b0};
    tbl[1] = '{32'h14,  32'h2009_0007, 1'b0};
    tbl[2] = '{32'h3FC, 32'hA5A5_0001, 1'b0};
    tbl[3] = '{32'h000, 32'h5A5A_0002, 1'b0};
    tbl[4] = '{32'h02,  32'h0,         1'b1};
    tbl[5] = '{32'h400, 32'h0,         1'b1};
    tbl[6] = '{32'h04,  32'h0,         1'b0};
    tbl[7] = '{32'h13,  32'h0,         1'b1};
    tbl[8] = '{32'hFFFF_FFFC, 32'h0,   1'b1};
    for (int i = 0; i < 9; i++) begin
      fetch_en = 1'b1; fetch_addr = tbl[i].addr;
      tick();
      chk($sformatf("tbl[%0d] valid", i), 64'(instr_valid), 64'(1));
      chk($sformatf("tbl[%0d] instr", i), 64'(instruction), 64'(tbl[i].instr));
      chk($sformatf("tbl[%0d] err", i),   64'(addr_error),  64'(tbl[i].err));
    end
    fetch_en = 1'b0;
    tick();
    chk("idle no fetch valid", 64'(instr_valid), 64'(0));

    // Stall holds the 0x10 result while a new address is presented.
    fetch_en = 1'b1; fetch_addr = 32'h10;
    tick();
    fetch_stall = 1'b1; fetch_addr = 32'h14;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall hold instr", 64'(instruction), 64'(32'h2008_0005));
      chk("stall hold valid", 64'(instr_valid), 64'(1));
    end
    fetch_stall = 1'b0;
    tick();
    chk("post-stall instr", 64'(instruction), 64'(32'h2009_0007));
    fetch_en = 1'b0;

    // Restart in LOAD: the word presented with load_start is dropped.
    load_start = 1'b1; load_base = 32'h40;
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'h1111_1111;
    tick();
    m_mem[32'h10] = 32'h1111_1111;
    load_start = 1'b1; load_base = 32'h80; load_data = 32'h2222_2222; load_last = 1'b1;
    tick();
    load_start = 1'b0;
    chk("restart count", 64'(load_count), 64'(0));
    chk("restart busy", 64'(busy), 64'(1));
    chk("restart no done", 64'(load_done), 64'(0));
    load_data = 32'h3333_3333;
    tick();
    m_mem[32'h20] = 32'h3333_3333;
    load_valid = 1'b0; load_last = 1'b0;
    chk("restart done", 64'(load_done), 64'(1));
    chk("restart final count", 64'(load_count), 64'(1));
    fetch_chk(32'h40, "restart first word");
    fetch_chk(32'h80, "restart base word");
    fetch_chk(32'h84, "dropped word absent");

    // load_valid in IDLE must not write.
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("idle load_ready", 64'(load_ready), 64'(0));
    load_valid = 1'b0;
    fetch_chk(32'h88, "no idle write");

    // Randomized loads and fetches.
    for (int it = 0; it < 20; it++) begin
      q = {};
      repeat ($urandom_range(1, 6)) q.push_back($urandom);
      do_load($urandom, q, 1'b1);
      for (int k = 0; k < 4; k++) begin
        a = 32'($urandom_range(0, 32'h4FF));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        fetch_chk(a, "random fetch");
      end
    end
    q = {};
    repeat (260) q.push_back($urandom);
    do_load(32'h0, q, 1'b0);
    for (int k = 0; k < 6; k++) begin
      a = 32'($urandom_range(0, 255)) << 2;
      fetch_chk(a, "post-saturate fetch");
    end

    // Fetch during LOAD is suppressed; reset mid-LOAD restarts the clear.
    load_start = 1'b1; load_base = 32'h0;
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'hCAFE_F00D;
    fetch_en = 1'b1; fetch_addr = 32'h10;
    tick();
    chk("fetch in LOAD valid", 64'(instr_valid), 64'(0));
    chk("fetch in LOAD instr", 64'(instruction), 64'(0));
    chk("busy in LOAD", 64'(busy), 64'(1));
    load_valid = 1'b0; fetch_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset mid-load busy", 64'(busy), 64'(1));
    chk("reset mid-load done", 64'(load_done), 64'(0));
    count_clear("reclear");
    fetch_chk(32'h00, "after reclear 0x00");
    fetch_chk(32'h10, "after reclear 0x10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory for the IF stage with a streaming program-load port and a registered fetch port.
- Replaces the byte-array, combinational-read instruction memory.
- Adds a sequential clear engine, an auto-incrementing valid/ready loader (driven by the debug/UART unit) and a 1-cycle synchronous fetch.
- Reports address errors and overflow.
- Fetch is only served when the block is neither clearing nor loading.

Parameters:
DATA_W, 32, instruction/word width in bits (multiple of 8)
DEPTH_WORDS, 256, number of words (power of 2, >=4)
ADDR_W, 32, byte-address width of load_base/fetch_addr
CLEAR_ON_RESET, 1, 1 = sweep memory to zero after reset; 0 = contents retained across reset

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
load_start  in  1  1-cycle pulse: begin/restart load at load_base
load_base  in  ADDR_W  byte start address, sampled with load_start
load_valid  in  1  load_data valid
load_data  in  DATA_W  word to write
load_last  in  1  qualifies final word of program
load_ready  out  1  loader accepts a word
load_done  out  1  1-cycle pulse after last word written
load_count  out  $clog2(DEPTH_WORDS)+1  words written since load_start
load_overflow  out  1  sticky: write pointer wrapped during the load
fetch_en  in  1  request fetch at fetch_addr
fetch_addr  in  ADDR_W  byte address (PC)
fetch_stall  in  1  hold current fetch output
instruction  out  DATA_W  fetched word, registered
instr_valid  out  1  instruction valid
addr_error  out  1  the fetch that produced the current instruction was misaligned or out of range
busy  out  1  state is CLEAR or LOAD

Behaviour:
Reset:
- All outputs 0; clr_ptr=0; wr_ptr=0.
- Next state is CLEAR if CLEAR_ON_RESET, else IDLE.
- A reset asserted mid-CLEAR or mid-LOAD aborts the operation immediately; words already written stay written, then the clear restarts.

CLEAR:
- Writes 0 to word clr_ptr each cycle; busy=1; load_ready=0.
- Lasts exactly DEPTH_WORDS cycles, then IDLE.
- load_start is ignored while in CLEAR.

IDLE:
- load_start: enter LOAD; wr_ptr=load_base[ADDR_W-1:2] mod DEPTH_WORDS; load_count=0; load_overflow=0.
- load_base[1:0]!=0: the low bits are dropped (word aligned).

LOAD:
- load_ready=1.
- On each cycle with load_valid&&load_ready: mem[wr_ptr]<=load_data; wr_ptr++; load_count++.
- Wrap: a write at word DEPTH_WORDS-1 sets wr_ptr=0 and load_overflow=1.
- load_count saturates at DEPTH_WORDS.
- Handshake with load_last=1: next state IDLE; load_done=1 on the following cycle only.
- load_start while in LOAD: restarts pointer/count; the same-cycle handshake word is dropped.

Fetch:
- Word index = fetch_addr[ADDR_W-1:2]. Little-endian: byte address A+0 is data[7:0].
- Latency: 1 cycle.
- Served only in IDLE with fetch_stall=0 and fetch_en=1; instruction<=mem[idx]; instr_valid<=1; addr_error<=0.
- Error: fetch_addr[1:0]!=0 or idx>=DEPTH_WORDS gives instruction<=0 (NOP), instr_valid<=1, addr_error<=1.
- fetch_stall=1: instruction, instr_valid and addr_error hold, regardless of state or fetch_en.
- Not stalled and (fetch_en=0 or state!=IDLE): instruction<=0, instr_valid<=0, addr_error<=0.
- No read/write collision is possible, because fetch is gated to IDLE.

Optional Feature:
IMEM_PARITY_EN:
- Defined: each word stores an extra even-parity bit, computed on load and clear writes.
- Defined: output parity_error (1 bit) is registered alongside instruction. It is 1 when the stored parity mismatches, follows the same hold/clear rules as addr_error, and resets to 0.
- Undefined: no parity storage and no parity_error port.

Decomposition:
Package imem_pkg holds:
- state enum {CLEAR, IDLE, LOAD}
- NOP_WORD constant (all zeros)
- function word_idx(addr) and function in_range(idx, depth)

Sub-module imem_ram is natural:
- 1 write port, 1 synchronous read port, DEPTH_WORDS x (DATA_W [+1 parity]).
- Holds its output on a read-enable-low cycle.
- Top level keeps the FSM, pointers and output registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles; then fetch 0x3FC -> instruction=0, instr_valid=1 one cycle later.
- load_start, base 0x10; stream 0x20080005, 0x20090007 with last on the second -> load_done pulses once, load_count=2; fetch 0x10 gives 0x20080005, fetch 0x14 gives 0x20090007.
- Load from base 0x3FC with 2 words -> second word lands at 0x000, load_overflow=1, load_count=2.
- Fetch 0x02 -> addr_error=1, instruction=0. Fetch 0x400 -> addr_error=1. Fetch 0x04 -> addr_error=0.
- Assert fetch_stall for 3 cycles after fetching 0x10 -> instruction/instr_valid held through the stall; the new fetch appears 1 cycle after release.
- load_valid with no load_start, and fetch during LOAD -> no write occurs, instr_valid=0; reset mid-LOAD -> busy restarts CLEAR and load_done never pulses.
